circle_op_arbiter: RTL and testbench

//  Round-robin arbiter sharing one circle_drawing_engine between NUM_REQ op

---
 rtl/circle_op_arbiter.sv | 146 ++++++++++++++
 tb/tb_circle_op_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/circle_op_arbiter.sv
// Round-robin arbiter feeding one circle engine from NUM_REQ op sources.
// Drops r==0 ops, registers the winning op for the engine handshake and
// limits the number of circles issued but not yet completed.
module circle_op_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned LOG2_REQ        = 2,
    parameter int unsigned OP_WIDTH        = 42,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned CNT_WIDTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst_,
    input  logic [NUM_REQ*OP_WIDTH-1:0] req_op,
    input  logic [NUM_REQ-1:0]          req_rts,
    output logic [NUM_REQ-1:0]          req_rtr,
    output logic [OP_WIDTH-1:0]         eng_op,
    output logic                        eng_rts,
    input  logic                        eng_rtr,
    input  logic                        eng_done,
    output logic [LOG2_REQ-1:0]         grant_id,
    output logic [CNT_WIDTH-1:0]        outstanding,
    output logic [15:0]                 drop_cnt,
    output logic                        err_underflow
);

    localparam int unsigned R_LSB = 12;
    localparam int unsigned R_W   = 10;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LOG2_REQ-1:0]   r_rr_ptr;
    logic [OP_WIDTH-1:0]   r_eng_op;
    logic                  r_eng_rts;
    logic [LOG2_REQ-1:0]   r_grant_id;
    logic [CNT_WIDTH-1:0]  r_outstanding;
    logic [15:0]           r_drop_cnt;
    logic                  r_err_underflow;

    logic                  w_found;
    logic [LOG2_REQ-1:0]   w_winner;
    int unsigned           w_idx;
    logic [OP_WIDTH-1:0]   w_win_op;
    logic                  w_r_nz;
    logic                  w_eligible;
    logic                  w_accept;
    logic                  w_issue;
    logic [LOG2_REQ-1:0]   w_ptr_nxt;

    // Round-robin scan starting at r_rr_ptr
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = (32'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && req_rts[w_idx]) begin
                w_found  = 1'b1;
                w_winner = LOG2_REQ'(w_idx);
            end
        end
    end

    assign w_win_op   = req_op[32'(w_winner)*OP_WIDTH +: OP_WIDTH];
    assign w_r_nz     = |w_win_op[R_LSB +: R_W];
    assign w_eligible = (r_outstanding < CNT_WIDTH'(MAX_OUTSTANDING));
    assign w_issue    = (r_state == S_ISSUE) && eng_rtr;
    assign w_ptr_nxt  = (w_winner == LOG2_REQ'(NUM_REQ - 1)) ? '0 : w_winner + LOG2_REQ'(1);

    // State register
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state and combinational accept handshake
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req_rtr     = '0;
        case (r_state)
            S_IDLE: begin
                if (!rst_ && w_eligible && w_found) begin
                    w_accept = 1'b1;
                    req_rtr  = NUM_REQ'(1) << w_winner;
                    if (w_r_nz) w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (eng_rtr) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Op capture, rr pointer, drop counter and engine valid
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_rr_ptr   <= '0;
            r_eng_op   <= '0;
            r_grant_id <= '0;
            r_eng_rts  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_eng_rts <= (w_state_nxt == S_ISSUE);
            if (w_accept) begin
                r_rr_ptr <= w_ptr_nxt;
                if (w_r_nz) begin
                    r_eng_op   <= w_win_op;
                    r_grant_id <= w_winner;
                end else if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
        end
    end

    // Outstanding credit counter with sticky underflow flag
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_outstanding   <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            case ({w_issue, eng_done})
                2'b10: r_outstanding <= r_outstanding + CNT_WIDTH'(1);
                2'b01: begin
                    if (r_outstanding == '0) r_err_underflow <= 1'b1;
                    else                     r_outstanding   <= r_outstanding - CNT_WIDTH'(1);
                end
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign eng_op        = r_eng_op;
    assign eng_rts       = r_eng_rts;
    assign grant_id      = r_grant_id;
    assign outstanding   = r_outstanding;
    assign drop_cnt      = r_drop_cnt;
    assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_circle_op_arbiter.sv
// Bench for circle_op_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of the arbiter.
module tb_circle_op_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned OW = 42;

    logic            clk;
    logic            rst_;
    logic [NR*OW-1:0] req_op;
    logic [NR-1:0]   req_rts;
    logic [NR-1:0]   req_rtr;
    logic [OW-1:0]   eng_op;
    logic            eng_rts;
    logic            eng_rtr;
    logic            eng_done;
    logic [1:0]      grant_id;
    logic [3:0]      outstanding;
    logic [15:0]     drop_cnt;
    logic            err_underflow;

    logic [OW-1:0]   ops [NR];

    int errors = 0;
    int checks = 0;

    // reference model state
    int          m_ptr, m_out, m_drop, m_id;
    bit          m_err, m_busy;
    logic [OW-1:0] m_op;
    logic [NR-1:0] m_acc;

    circle_op_arbiter dut (
        .clk(clk), .rst_(rst_), .req_op(req_op), .req_rts(req_rts), .req_rtr(req_rtr),
        .eng_op(eng_op), .eng_rts(eng_rts), .eng_rtr(eng_rtr), .eng_done(eng_done),
        .grant_id(grant_id), .outstanding(outstanding), .drop_cnt(drop_cnt),
        .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_op = '0;
        for (int i = 0; i < NR; i++) req_op[i*OW +: OW] = ops[i];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] mk_op(input int x, input int y, input int r, input int c);
        return {10'(x), 10'(y), 10'(r), 12'(c)};
    endfunction

    function automatic logic [OW-1:0] rand_op();
        logic [9:0] r;
        r = ($urandom % 4 == 0) ? 10'd0 : 10'($urandom);
        return {10'($urandom), 10'($urandom), r, 12'($urandom)};
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_out = 0; m_drop = 0; m_id = 0;
        m_err = 0; m_busy = 0; m_op = '0; m_acc = '0;
    endtask

    // One clock cycle: check DUT against model, advance model, clock.
    task automatic step();
        int win;
        logic [NR-1:0] exp_rtr;
        logic [OW-1:0] wop;
        bit issue;
        #1;
        win = -1;
        if (!m_busy && m_out < 8) begin
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (m_ptr + k) % NR;
                if (win < 0 && req_rts[idx]) win = idx;
            end
        end
        exp_rtr = (win >= 0) ? NR'(1 << win) : '0;
        chk("req_rtr", 64'(req_rtr), 64'(exp_rtr));
        chk("eng_rts", 64'(eng_rts), 64'(m_busy));
        chk("eng_op", 64'(eng_op), 64'(m_op));
        chk("grant_id", 64'(grant_id), 64'(m_id));
        chk("outstanding", 64'(outstanding), 64'(m_out));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("err_underflow", 64'(err_underflow), 64'(m_err));
        m_acc = exp_rtr;
        issue = m_busy && eng_rtr;
        if (issue) m_busy = 0;
        if (issue && !eng_done) m_out++;
        else if (eng_done && !issue) begin
            if (m_out == 0) m_err = 1;
            else m_out--;
        end
        if (win >= 0) begin
            m_ptr = (win + 1) % NR;
            wop = ops[win];
            if (wop[21:12] == 10'd0) begin
                if (m_drop < 65535) m_drop++;
            end else begin
                m_busy = 1; m_op = wop; m_id = win;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_ = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_rtr", 64'(req_rtr), 64'd0);
        chk("rst_eng_rts", 64'(eng_rts), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        rst_ = 1'b0;
    endtask

    initial begin
        logic [OW-1:0] op1, held;
        int seq[$];
        int exp_seq[6];
        exp_seq = '{0, 1, 2, 3, 0, 1};
        rst_ = 1'b1; req_rts = '0; eng_rtr = 0; eng_done = 0;
        for (int i = 0; i < NR; i++) ops[i] = '0;
        model_reset();
        @(negedge clk);
        req_rts = 4'b1111;
        do_reset();
        req_rts = '0;

        // 1: single op
        op1 = mk_op(100, 80, 20, 12'hF00);
        ops[0] = op1; req_rts = 4'b0001;
        #1 chk("t1_rtr", 64'(req_rtr), 64'h1);
        step();
        req_rts = '0; eng_rtr = 1;
        chk("t1_eng_rts", 64'(eng_rts), 64'd1);
        chk("t1_eng_op", 64'(eng_op), 64'(op1));
        chk("t1_grant", 64'(grant_id), 64'd0);
        step();
        chk("t1_outstanding", 64'(outstanding), 64'd1);

        // 2: fairness
        do_reset();
        for (int i = 0; i < NR; i++) ops[i] = mk_op(i * 10, i * 20, i + 1, i);
        req_rts = 4'b1111; eng_rtr = 1;
        for (int c = 0; c < 12; c++) begin
            eng_done = m_busy;
            step();
            if (eng_rts) seq.push_back(int'(grant_id));
        end
        eng_done = 0;
        chk("t2_seq_len", 64'(seq.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            chk("t2_grant_seq", 64'(seq[i]), 64'(exp_seq[i]));

        // 3: degenerate drop
        do_reset();
        req_rts = 4'b0100; ops[2] = mk_op(5, 5, 0, 1); eng_rtr = 0;
        step();
        chk("t3_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("t3_no_rts", 64'(eng_rts), 64'd0);
        req_rts = 4'b1000; ops[3] = mk_op(7, 8, 9, 3);
        #1 chk("t3_rtr", 64'(req_rtr), 64'h8);
        step();
        req_rts = '0; eng_rtr = 1;
        chk("t3_eng_rts", 64'(eng_rts), 64'd1);
        chk("t3_grant", 64'(grant_id), 64'd3);
        step();

        // 4: credit limit
        do_reset();
        for (int i = 0; i < NR; i++) ops[i] = mk_op(i, i, 3 + i, i);
        req_rts = 4'b1111; eng_rtr = 1; eng_done = 0;
        for (int c = 0; c < 20; c++) step();
        chk("t4_out_max", 64'(outstanding), 64'd8);
        chk("t4_stall", 64'(req_rtr), 64'd0);
        eng_done = 1;
        step();
        eng_done = 0;
        chk("t4_out_7", 64'(outstanding), 64'd7);
        chk("t4_resume", 64'(req_rtr != '0), 64'd1);
        step();

        // 5: backpressure and coincident issue/done
        do_reset();
        req_rts = 4'b0001; ops[0] = mk_op(1, 2, 3, 4); eng_rtr = 1;
        for (int c = 0; c < 6; c++) step();
        chk("t5_out_3", 64'(outstanding), 64'd3);
        eng_rtr = 0;
        step();
        req_rts = '0;
        held = eng_op;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t5_hold_op", 64'(eng_op), 64'(held));
            chk("t5_hold_rts", 64'(eng_rts), 64'd1);
        end
        eng_rtr = 1; eng_done = 1;
        step();
        eng_done = 0;
        chk("t5_coincide", 64'(outstanding), 64'd3);

        // 6: underflow and reset mid-issue
        do_reset();
        eng_done = 1;
        step();
        eng_done = 0;
        chk("t6_err", 64'(err_underflow), 64'd1);
        for (int c = 0; c < 3; c++) step();
        chk("t6_err_sticky", 64'(err_underflow), 64'd1);
        req_rts = 4'b0010; ops[1] = mk_op(3, 3, 3, 3); eng_rtr = 0;
        step();
        chk("t6_in_issue", 64'(eng_rts), 64'd1);
        rst_ = 1'b1;
        #1;
        chk("t6_async_rts", 64'(eng_rts), 64'd0);
        chk("t6_async_op", 64'(eng_op), 64'd0);
        chk("t6_async_err", 64'(err_underflow), 64'd0);
        chk("t6_async_rtr", 64'(req_rtr), 64'd0);
        @(negedge clk);
        req_rts = '0;
        do_reset();

        // random traffic against the model
        for (int i = 0; i < NR; i++) begin
            ops[i] = rand_op();
            req_rts[i] = 1'($urandom % 2);
        end
        for (int c = 0; c < 600; c++) begin
            eng_rtr  = ($urandom % 3) != 0;
            eng_done = ($urandom % 4) == 0;
            step();
            for (int i = 0; i < NR; i++) begin
                if (!req_rts[i] || m_acc[i]) begin
                    req_rts[i] = 1'($urandom % 2);
                    ops[i] = rand_op();
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
